// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: master-clock divider -> pixel enable, h/v counters, sync + blanked RGB.
// Latency: counters/video_on registered; hsync/vsync/rgb_out lag the raster position by one pixel tick.
// Backpressure: none; free-running raster, outputs hold between pixel ticks.
//
// Ports:
//   clk, clr             master clock, asynchronous active-high reset
//   pix_ce               one-clk pulse per pixel tick
//   hcount, vcount       raster position (registered, change only on pixel-tick edges)
//   video_on             position is inside the visible area
//   vblank_tick          one-clk strobe at the first tick of vertical blanking
//   rgb_in               user colour for the current (hcount, vcount)
//   hsync, vsync, rgb_out  connector-side signals, mutually aligned
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10,
  parameter int   RGB_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  output logic             pix_ce,
  output logic [CW-1:0]    hcount,
  output logic [CW-1:0]    vcount,
  output logic             video_on,
  output logic             vblank_tick,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // (0,0) is visible whenever the active area is non-empty, so video_on
  // resets to that value to stay consistent with the reset counters.
  localparam logic VON_RST = (H_ACTIVE > 0) && (V_ACTIVE > 0);

  logic [CW-1:0] div;
  logic [CW-1:0] div_nxt;
  logic          ce_nxt;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;

  // Next-state of the divider and raster counters. pix_ce is registered from
  // the divider's next value so it lines up with the count it describes and
  // reads 0 while in reset even when CLK_DIV=1. The >= compares make any
  // out-of-range count fall back to 0 on the next wrap decision.
  always_comb begin
    div_nxt = (div >= DIV_LAST) ? '0 : div + ONE;
    ce_nxt  = (div_nxt == DIV_LAST);
    h_nxt   = hcount;
    v_nxt   = vcount;
    if (pix_ce) begin
      if (hcount >= H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcount >= V_LAST) ? '0 : vcount + ONE;
      end else begin
        h_nxt = hcount + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      video_on    <= VON_RST;
      vblank_tick <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      rgb_out     <= '0;
    end else begin
      div      <= div_nxt;
      pix_ce   <= ce_nxt;
      hcount   <= h_nxt;
      vcount   <= v_nxt;
      // Derived from the next counts so flags and counters agree every cycle.
      video_on <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      // Only the tick cycle of pixel (0, V_ACTIVE) strobes; hcount sits at 0
      // for CLK_DIV cycles but only one of them carries pix_ce.
      vblank_tick <= ce_nxt && (h_nxt == '0) && (v_nxt == V_ACT);

      // Connector stage samples the current position, giving one tick of lag
      // that is identical for sync and colour.
      if (pix_ce) begin
        rgb_out <= video_on ? rgb_in : '0;
        hsync   <= ((hcount >= HS_START) && (hcount <= HS_END)) ? HS_POL : ~HS_POL;
        vsync   <= ((vcount >= VS_START) && (vcount <= VS_END)) ? VS_POL : ~VS_POL;
      end
    end
  end

endmodule
